// File: rtl/alu_regfile_datapath.sv
// Integer execute datapath: 32 x XLEN register file (x0 reads zero) feeding an RV32I-style ALU, result written back to rd.
// Latency: result/rs1_value/rs2_value/error are combinational; write-back commits on the rising clk edge.
// Backpressure: none; one instruction is accepted every cycle, and write_enable gates the commit.
//
// Ports:
//   clk, reset_n         clock, synchronous active-low reset (clears all registers)
//   write_enable, rd     commit result to rd on this edge (rd == 0 discarded)
//   op                   ALU op code {funct7[5], funct3}
//   rs1, rs2             source register addresses
//   has_immediate, imm   operand B select: sign-extended 12-bit imm, or rs2 contents
//   result, error        ALU result (also write-back data); error flags an undefined op
//   rs1_value, rs2_value current source register contents
module alu_regfile_datapath #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            write_enable,
   input  logic [3:0]      op,
   input  logic [4:0]      rd,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   input  logic            has_immediate,
   input  logic [11:0]     imm,
   output logic [XLEN-1:0] result,
   output logic [XLEN-1:0] rs1_value,
   output logic [XLEN-1:0] rs2_value,
   output logic            error
);

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b1000,
      OP_SLL  = 4'b0001,
      OP_SLT  = 4'b0010,
      OP_SLTU = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_SRL  = 4'b0101,
      OP_SRA  = 4'b1101,
      OP_OR   = 4'b0110,
      OP_AND  = 4'b0111
   } alu_op_e;

   logic [XLEN-1:0] regs [NREGS];
   logic [XLEN-1:0] operand_a;
   logic [XLEN-1:0] operand_b;
   logic [4:0]      shamt;

   // x0 is forced to zero on the read side, so its storage never matters.
   assign rs1_value = (rs1 == 5'd0) ? '0 : regs[rs1];
   assign rs2_value = (rs2 == 5'd0) ? '0 : regs[rs2];

   assign operand_a = rs1_value;
   assign operand_b = has_immediate ? {{(XLEN-12){imm[11]}}, imm} : rs2_value;
   assign shamt     = operand_b[4:0];

   always_comb begin
      result = '0;
      error  = 1'b0;
      case (op)
         OP_ADD:  result = operand_a + operand_b;
         OP_SUB:  result = operand_a - operand_b;
         OP_SLL:  result = operand_a << shamt;
         OP_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
         OP_SLTU: result = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
         OP_XOR:  result = operand_a ^ operand_b;
         OP_SRL:  result = operand_a >> shamt;
         OP_SRA:  result = $unsigned($signed(operand_a) >>> shamt);
         OP_OR:   result = operand_a | operand_b;
         OP_AND:  result = operand_a & operand_b;
         default: begin
            result = '0;
            error  = 1'b1;
         end
      endcase
   end

   // No bypass: a same-cycle read of rd sees the pre-write value.
   // Undefined ops still commit their zero result when enabled.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (write_enable && (rd != 5'd0)) begin
         regs[rd] <= result;
      end
   end

endmodule

// File: tb/tb_alu_regfile_datapath.sv
module tb_alu_regfile_datapath;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        write_enable;
   logic [3:0]  op;
   logic [4:0]  rd, rs1, rs2;
   logic        has_immediate;
   logic [11:0] imm;
   logic [31:0] result, rs1_value, rs2_value;
   logic        error;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] model_regs [32];
   logic [32:0] exp_q [$];

   localparam logic [3:0] ADD = 4'b0000, SUB = 4'b1000, SLL = 4'b0001, SLT = 4'b0010,
                          SLTU = 4'b0011, XOR = 4'b0100, SRL = 4'b0101, SRA = 4'b1101,
                          OR = 4'b0110, AND = 4'b0111;

   alu_regfile_datapath #(.XLEN(32), .NREGS(32)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .write_enable  (write_enable),
      .op            (op),
      .rd            (rd),
      .rs1           (rs1),
      .rs2           (rs2),
      .has_immediate (has_immediate),
      .imm           (imm),
      .result        (result),
      .rs1_value     (rs1_value),
      .rs2_value     (rs2_value),
      .error         (error)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%09h expected 0x%09h", tag, obs, exp);
      end
   endtask

   // Independent reference: {error, result}
   function automatic logic [32:0] alu_model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [4:0]  sh;
      logic [31:0] r;
      sh = b[4:0];
      r  = 32'h0;
      case (o)
         ADD:  r = a + b;
         SUB:  r = a + ~b + 32'd1;
         SLL:  r = a << sh;
         SLT:  r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
         SLTU: r = (a < b) ? 32'd1 : 32'd0;
         XOR:  r = a ^ b;
         SRL:  r = a >> sh;
         SRA:  r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
         OR:   r = a | b;
         AND:  r = a & b;
         default: return {1'b1, 32'h0};
      endcase
      return {1'b0, r};
   endfunction

   task automatic exec(input logic [3:0] o, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic h, input logic [11:0] im, input logic w);
      logic [31:0] b;
      logic [32:0] exp, got;
      @(negedge clk);
      op = o; rd = d; rs1 = s1; rs2 = s2; has_immediate = h; imm = im; write_enable = w;
      b = h ? {{20{im[11]}}, im} : model_regs[s2];
      exp_q.push_back(alu_model(o, model_regs[s1], b));
      #1;
      got = exp_q.pop_front();
      check_val($sformatf("exec op=%b rd=%0d", o, d), {error, result}, got);
      @(posedge clk);
      if (w && d != 5'd0) model_regs[d] = got[31:0];
   endtask

   task automatic read_reg(input logic [4:0] r, input logic [31:0] exp);
      @(negedge clk);
      write_enable = 1'b0; rs1 = r; rs2 = r;
      #1;
      check_val($sformatf("rs1_value r%0d", r), {1'b0, rs1_value}, {1'b0, exp});
      check_val($sformatf("rs2_value r%0d", r), {1'b0, rs2_value}, {1'b0, exp});
   endtask

   initial begin
      reset_n = 1'b0; write_enable = 1'b1; op = ADD; rd = 5'd5; rs1 = 5'd0; rs2 = 5'd0;
      has_immediate = 1'b1; imm = 12'd99;
      for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;

      // Reset with a pending write to r5; reset must win.
      @(posedge clk);
      @(negedge clk);
      rs1 = 5'd5;
      #1;
      check_val("reset result f(ADD,0,99)", {error, result}, {1'b0, 32'd99});
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1; write_enable = 1'b0;
      for (int i = 0; i < 32; i++) read_reg(i[4:0], 32'h0);

      // Dependent program
      exec(ADD, 5'd1, 5'd0, 5'd0, 1'b1, 12'd10, 1'b1);
      exec(ADD, 5'd1, 5'd1, 5'd0, 1'b1, 12'd40, 1'b1);
      exec(ADD, 5'd2, 5'd1, 5'd0, 1'b1, 12'd10, 1'b1);
      exec(ADD, 5'd3, 5'd2, 5'd0, 1'b1, 12'd1,  1'b1);
      exec(ADD, 5'd4, 5'd3, 5'd0, 1'b1, 12'd1,  1'b1);
      exec(SUB, 5'd5, 5'd4, 5'd1, 1'b0, 12'd0,  1'b1);
      exec(AND, 5'd6, 5'd1, 5'd2, 1'b0, 12'd0,  1'b1);
      read_reg(5'd1, 32'd50);
      read_reg(5'd2, 32'd60);
      read_reg(5'd3, 32'd61);
      read_reg(5'd4, 32'd62);
      read_reg(5'd5, 32'd12);
      read_reg(5'd6, 32'd48);

      // x0 behaviour
      exec(ADD, 5'd0, 5'd0, 5'd0, 1'b1, 12'd123, 1'b1);
      read_reg(5'd0, 32'h0);
      exec(ADD, 5'd7, 5'd0, 5'd0, 1'b1, 12'd5, 1'b1);
      exec(ADD, 5'd7, 5'd0, 5'd0, 1'b0, 12'd0, 1'b1);
      read_reg(5'd7, 32'h0);

      // Sign extension and compares
      exec(ADD,  5'd8,  5'd0, 5'd0, 1'b1, 12'hFFF, 1'b1);
      exec(ADD,  5'd9,  5'd0, 5'd0, 1'b1, 12'd1,   1'b1);
      exec(SLT,  5'd10, 5'd8, 5'd9, 1'b0, 12'd0,   1'b1);
      exec(SLTU, 5'd11, 5'd8, 5'd9, 1'b0, 12'd0,   1'b1);
      exec(SUB,  5'd12, 5'd0, 5'd9, 1'b0, 12'd0,   1'b1);
      read_reg(5'd8,  32'hFFFF_FFFF);
      read_reg(5'd10, 32'd1);
      read_reg(5'd11, 32'd0);
      read_reg(5'd12, 32'hFFFF_FFFF);

      // Shifts of 0x80000000 by 4 and by 36
      exec(ADD, 5'd13, 5'd0,  5'd0, 1'b1, 12'd1,  1'b1);
      exec(SLL, 5'd14, 5'd13, 5'd0, 1'b1, 12'd31, 1'b1);
      exec(SLL, 5'd15, 5'd14, 5'd0, 1'b1, 12'd4,  1'b1);
      exec(SRL, 5'd16, 5'd14, 5'd0, 1'b1, 12'd4,  1'b1);
      exec(SRA, 5'd17, 5'd14, 5'd0, 1'b1, 12'd4,  1'b1);
      read_reg(5'd14, 32'h8000_0000);
      read_reg(5'd15, 32'h0);
      read_reg(5'd16, 32'h0800_0000);
      read_reg(5'd17, 32'hF800_0000);
      exec(ADD, 5'd19, 5'd0,  5'd0,  1'b1, 12'd36, 1'b1);
      exec(SRA, 5'd20, 5'd14, 5'd19, 1'b0, 12'd0,  1'b1);
      exec(SRL, 5'd21, 5'd14, 5'd0,  1'b1, 12'd36, 1'b1);
      read_reg(5'd20, 32'hF800_0000);
      read_reg(5'd21, 32'h0800_0000);

      // Undefined op commits zero; write_enable=0 leaves registers alone
      exec(ADD, 5'd18, 5'd0, 5'd0, 1'b1, 12'd7, 1'b1);
      exec(4'b1111, 5'd18, 5'd1, 5'd2, 1'b0, 12'd0, 1'b1);
      read_reg(5'd18, 32'h0);
      exec(ADD, 5'd1, 5'd0, 5'd0, 1'b1, 12'd777, 1'b0);
      exec(4'b1010, 5'd2, 5'd0, 5'd0, 1'b1, 12'd1, 1'b0);
      read_reg(5'd1, 32'd50);
      read_reg(5'd2, 32'd60);

      // Random traffic against the model
      for (int k = 0; k < 60; k++) begin
         exec(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 12'($urandom),
              1'($urandom_range(0, 3) != 0));
      end
      for (int i = 0; i < 32; i++) read_reg(i[4:0], model_regs[i]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
